// File: rtl/qsfp_link_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : qsfp_link_stream_buffer
// Description : Elastic buffer between the shim's QSFP TX stream and the
//               serial-link TX interface. It absorbs link backpressure and
//               forwards traffic only after channel_up has been stable for
//               UP_HOLD cycles. On link loss it flushes its contents and keeps
//               accepting and dropping beats, so the shim cannot deadlock.
//               Optional beat statistics: define QSFP_LINK_BUF_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module qsfp_link_stream_buffer #(
    parameter int DATA_W  = 256,
    parameter int DEPTH   = 16,
    parameter int UP_HOLD = 64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     channel_up,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_bits,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_bits,
    output logic                     link_active,
    output logic [$clog2(DEPTH):0]   fifo_count
`ifdef QSFP_LINK_BUF_STATS_EN
    ,
    output logic [31:0]              stat_fwd_beats,
    output logic [31:0]              stat_drop_beats
`endif
);

    localparam int c_PTR_W  = $clog2(DEPTH);
    localparam int c_CNT_W  = c_PTR_W + 1;
    localparam int c_HOLD_W = (UP_HOLD > 1) ? $clog2(UP_HOLD) : 1;

    localparam logic [c_CNT_W-1:0]  c_FULL      = c_CNT_W'(DEPTH);
    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(UP_HOLD - 1);

    typedef enum logic [1:0] {
        ST_DOWN = 2'd0,
        ST_HOLD = 2'd1,
        ST_UP   = 2'd2
    } state_t;

    state_t               r_state;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic [DATA_W-1:0]    r_mem [DEPTH];
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [DATA_W-1:0]    r_out_bits;
    logic                 r_link_active;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_store;
    logic [c_CNT_W-1:0]   w_count_pop;
    state_t               w_state_nxt;
    logic [c_HOLD_W-1:0]  w_hold_nxt;
    logic [c_PTR_W-1:0]   w_wr_nxt;
    logic [c_PTR_W-1:0]   w_rd_nxt;
    logic [c_CNT_W-1:0]   w_count_nxt;
    logic [DATA_W-1:0]    w_head_nxt;

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_bits    = r_out_bits;
    assign link_active = r_link_active;
    assign fifo_count  = r_count;

    // Next-state, pointer, occupancy and next-head computation. Pushes are
    // stored only in UP; in DOWN they are accepted and dropped. A link drop
    // in UP clears pointers and occupancy on the same edge, after letting the
    // pop of that cycle complete.
    always_comb begin
        w_push      = in_valid && r_in_ready;
        w_pop       = r_out_valid && out_ready;
        w_store     = w_push && (r_state == ST_UP);
        w_count_pop = r_count - c_CNT_W'(w_pop);
        w_state_nxt = r_state;
        w_hold_nxt  = '0;
        w_wr_nxt    = '0;
        w_rd_nxt    = '0;
        w_count_nxt = '0;
        w_head_nxt  = r_out_bits;
        case (r_state)
            ST_DOWN: begin
                if (channel_up) w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!channel_up) begin
                    w_state_nxt = ST_DOWN;
                end else if (r_hold_cnt == c_HOLD_LAST) begin
                    w_state_nxt = ST_UP;
                end else begin
                    w_hold_nxt = r_hold_cnt + c_HOLD_W'(1);
                end
            end
            ST_UP: begin
                if (!channel_up) begin
                    w_state_nxt = ST_DOWN;
                end else begin
                    w_rd_nxt    = r_rd_ptr + c_PTR_W'(w_pop);
                    w_wr_nxt    = r_wr_ptr + c_PTR_W'(w_store);
                    w_count_nxt = w_count_pop + c_CNT_W'(w_store);
                    // An empty queue (after this cycle's pop) makes the new
                    // beat the head; otherwise the head comes from storage.
                    w_head_nxt  = (w_store && (w_count_pop == '0)) ? in_bits
                                                                   : r_mem[w_rd_nxt];
                end
            end
            default: w_state_nxt = ST_DOWN;
        endcase
    end

    // Control state and registered outputs; handshake outputs are derived
    // from next state and next occupancy so nothing depends on out_ready.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= ST_DOWN;
            r_hold_cnt    <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_in_ready    <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_bits    <= '0;
            r_link_active <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_hold_cnt    <= w_hold_nxt;
            r_wr_ptr      <= w_wr_nxt;
            r_rd_ptr      <= w_rd_nxt;
            r_count       <= w_count_nxt;
            r_in_ready    <= (w_state_nxt == ST_DOWN) ||
                             ((w_state_nxt == ST_UP) && (w_count_nxt != c_FULL));
            r_out_valid   <= (w_count_nxt != '0);
            r_link_active <= (w_state_nxt == ST_UP);
            if (w_count_nxt != '0) r_out_bits <= w_head_nxt;
        end
    end

    // Beat storage; contents need no reset because occupancy gates reads.
    always_ff @(posedge clock) begin
        if (w_store) r_mem[r_wr_ptr] <= in_bits;
    end

`ifdef QSFP_LINK_BUF_STATS_EN
    logic [31:0]        r_stat_fwd;
    logic [31:0]        r_stat_drop;
    logic [32:0]        w_fwd_sum;
    logic [32:0]        w_drop_sum;
    logic [c_CNT_W-1:0] w_drop_inc;

    assign stat_fwd_beats  = r_stat_fwd;
    assign stat_drop_beats = r_stat_drop;

    // Dropped beats: one per beat taken in DOWN, or the whole remaining
    // occupancy (including a push accepted in that cycle) on a link drop.
    always_comb begin
        w_drop_inc = '0;
        if (w_push && (r_state == ST_DOWN)) begin
            w_drop_inc = c_CNT_W'(1);
        end else if ((r_state == ST_UP) && !channel_up) begin
            w_drop_inc = w_count_pop + c_CNT_W'(w_store);
        end
        w_fwd_sum  = {1'b0, r_stat_fwd} + 33'(w_pop);
        w_drop_sum = {1'b0, r_stat_drop} + 33'(w_drop_inc);
    end

    // Saturating statistics counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stat_fwd  <= '0;
            r_stat_drop <= '0;
        end else begin
            r_stat_fwd  <= w_fwd_sum[32]  ? 32'hFFFF_FFFF : w_fwd_sum[31:0];
            r_stat_drop <= w_drop_sum[32] ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_qsfp_link_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qsfp_link_stream_buffer
// Description : Self-checking bench for qsfp_link_stream_buffer. A queue-based
//               reference model predicts every output each cycle; directed
//               phases pin link-up timing, full/empty and flush behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qsfp_link_stream_buffer;

    localparam int DATA_W  = 256;
    localparam int DEPTH   = 16;
    localparam int UP_HOLD = 64;

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              channel_up = 1'b0;
    logic              in_valid   = 1'b0;
    logic              out_ready  = 1'b0;
    logic [DATA_W-1:0] in_bits    = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_bits;
    logic              link_active;
    logic [4:0]        fifo_count;
`ifdef QSFP_LINK_BUF_STATS_EN
    logic [31:0]       stat_fwd_beats;
    logic [31:0]       stat_drop_beats;
`endif

    int checks   = 0;
    int failures = 0;

    qsfp_link_stream_buffer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .UP_HOLD (UP_HOLD)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .channel_up  (channel_up),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bits     (in_bits),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bits    (out_bits),
        .link_active (link_active),
        .fifo_count  (fifo_count)
`ifdef QSFP_LINK_BUF_STATS_EN
        ,
        .stat_fwd_beats  (stat_fwd_beats),
        .stat_drop_beats (stat_drop_beats)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_beat();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: link is either up (forwarding queue) or not; while
    // not up, m_run counts consecutive high samples of channel_up. The
    // first high sample leaves DOWN, then UP_HOLD more are needed in HOLD.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] m_q[$];
    bit                m_up    = 1'b0;
    int                m_run   = 0;
    bit                m_fresh = 1'b1;
    longint            m_fwd   = 0;
    longint            m_drop  = 0;

    function automatic bit m_in_ready();
        if (m_up) return (m_q.size() != DEPTH);
        return (!m_fresh && (m_run == 0));
    endfunction

    function automatic bit m_out_valid();
        return m_up && (m_q.size() != 0);
    endfunction

    initial begin : model
        forever begin : step
            bit push;
            bit pop;
            @(posedge clock or posedge reset);
            if (reset) begin
                m_q.delete();
                m_up    = 1'b0;
                m_run   = 0;
                m_fresh = 1'b1;
                m_fwd   = 0;
                m_drop  = 0;
            end else begin
                push    = in_valid && m_in_ready();
                pop     = m_out_valid() && out_ready;
                m_fresh = 1'b0;
                if (m_up) begin
                    if (pop) begin
                        void'(m_q.pop_front());
                        m_fwd++;
                    end
                    if (push) m_q.push_back(in_bits);
                    if (!channel_up) begin
                        m_drop += m_q.size();
                        m_q.delete();
                        m_up  = 1'b0;
                        m_run = 0;
                    end
                end else begin
                    if (push) m_drop++;
                    m_run = channel_up ? m_run + 1 : 0;
                    if (m_run == UP_HOLD + 1) begin
                        m_up  = 1'b1;
                        m_run = 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clock) begin
        check("in_ready",    in_ready,    m_in_ready());
        check("out_valid",   out_valid,   m_out_valid());
        check("link_active", link_active, m_up);
        check("fifo_count",  fifo_count,  m_q.size());
        if (m_out_valid()) check("out_bits", out_bits, m_q[0]);
`ifdef QSFP_LINK_BUF_STATS_EN
        check("stat_fwd",  stat_fwd_beats,  m_fwd[31:0]);
        check("stat_drop", stat_drop_beats, m_drop[31:0]);
`endif
    end

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic wait_up();
        for (int k = 0; k < 300 && !link_active; k++) cyc();
        check("wait_up", link_active, 1'b1);
    endtask

    task automatic push_n(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_bits  = rnd_beat();
            cyc();
        end
        in_valid = 1'b0;
    endtask

    initial begin : stim
        int  n;
        int  acc;
        bit  seen;
`ifdef QSFP_LINK_BUF_STATS_EN
        logic [31:0] drop0;
`endif
        // Reset values
        repeat (3) cyc();
        check("rst_in_ready",    in_ready,    1'b0);
        check("rst_out_valid",   out_valid,   1'b0);
        check("rst_out_bits",    out_bits,    '0);
        check("rst_link_active", link_active, 1'b0);
        check("rst_fifo_count",  fifo_count,  5'd0);
        reset = 1'b0;
        cyc();

        // Link-up hold time; in_valid asserted to prove nothing gets in.
        in_valid   = 1'b1;
        in_bits    = rnd_beat();
        channel_up = 1'b1;
        @(posedge clock);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clock);
            #1;
            n++;
            if (link_active) break;
        end
        in_valid = 1'b0;
        check("hold_edges", n, UP_HOLD);
        cyc();
        check("up_empty_in_ready", in_ready, 1'b1);

        // Pulse of UP_HOLD-1 cycles never reaches UP
        channel_up = 1'b0;
        repeat (3) cyc();
        seen       = 1'b0;
        channel_up = 1'b1;
        repeat (UP_HOLD - 1) begin
            cyc();
            seen |= link_active | out_valid;
        end
        channel_up = 1'b0;
        repeat (UP_HOLD + 6) begin
            cyc();
            seen |= link_active | out_valid;
        end
        check("short_pulse_no_up", seen, 1'b0);

        // Fill with backpressure: 20 offered, exactly DEPTH accepted
        channel_up = 1'b1;
        wait_up();
        out_ready = 1'b0;
        acc       = 0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1;
            in_bits  = rnd_beat();
            if (in_ready) acc++;
            cyc();
        end
        in_valid = 1'b0;
        check("accepted", acc, DEPTH);
        check("full_count", fifo_count, 5'd16);
        check("full_in_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        cyc();
        check("ready_after_pop", in_ready, 1'b1);
        check("count_after_pop", fifo_count, 5'd15);
        repeat (20) cyc();
        check("drained", fifo_count, 5'd0);

        // Steady state at occupancy 5, full throughput, pointers wrap
        out_ready = 1'b0;
        push_n(5);
        out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            in_valid = 1'b1;
            in_bits  = rnd_beat();
            cyc();
            check("steady_count", fifo_count, 5'd5);
            check("steady_valid", out_valid, 1'b1);
        end
        in_valid = 1'b0;
        repeat (10) cyc();

        // Link drop with 7 buffered
        out_ready = 1'b0;
        push_n(7);
        check("pre_drop_count", fifo_count, 5'd7);
`ifdef QSFP_LINK_BUF_STATS_EN
        drop0 = stat_drop_beats;
`endif
        channel_up = 1'b0;
        cyc();
        check("drop_out_valid", out_valid, 1'b0);
        check("drop_count", fifo_count, 5'd0);
        check("drop_in_ready", in_ready, 1'b1);
        check("drop_link_active", link_active, 1'b0);
`ifdef QSFP_LINK_BUF_STATS_EN
        check("drop_stat_flush", stat_drop_beats, drop0 + 32'd7);
`endif
        push_n(3);
`ifdef QSFP_LINK_BUF_STATS_EN
        check("drop_stat_down", stat_drop_beats, drop0 + 32'd10);
`endif

        // Randomized traffic with occasional link drops
        channel_up = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ((k / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                              : ($urandom_range(0, 3) == 0);
            in_bits    = rnd_beat();
            channel_up = ($urandom_range(0, 599) != 0);
            cyc();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        channel_up = 1'b1;
        repeat (5) cyc();

        // Asynchronous reset mid-burst
        wait_up();
        out_ready = 1'b0;
        push_n(5);
        in_valid = 1'b1;
        in_bits  = rnd_beat();
        check("pre_reset_nonempty", fifo_count != 5'd0, 1'b1);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("arst_in_ready",    in_ready,    1'b0);
        check("arst_out_valid",   out_valid,   1'b0);
        check("arst_out_bits",    out_bits,    '0);
        check("arst_link_active", link_active, 1'b0);
        check("arst_fifo_count",  fifo_count,  5'd0);
        in_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        wait_up();
        out_ready = 1'b1;
        push_n(4);
        repeat (5) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
